wb_scoreboard: RTL and testbench

//   Single writer for the register file write port (reg_write/rd/wd).

---
 rtl/wb_scoreboard_if.sv | 65 ++++++
 rtl/wb_scoreboard.sv | 160 ++++++++++++++++
 tb/tb_wb_scoreboard.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_scoreboard_if.sv
// Purpose: bundles the execute-side result streams, issue/decode hazard signals and regfile write port of wb_scoreboard.
// Latency: none; this file only declares wires and modport directions.
// Backpressure: alu_ready / md_ready flow from the slave (scoreboard) back to the master (execute/decode side).
//
// Ports (signals):
//   issue_valid/issue_long/issue_rd  issued instruction, long-latency flag, destination
//   issue_waw                        advisory: long issue targets an already-busy register
//   alu_valid/alu_ready/alu_rd/alu_wd  single-cycle ALU result request
//   md_valid/md_ready/md_rd/md_wd      MUL/DIV result request into the skid buffer
//   rs1/rs2, rs1_busy/rs2_busy         decode source indices and RAW hazard flags
//   reg_write/rd/wd                    registered regfile write port
interface wb_scoreboard_if #(
    parameter int XLEN = 32
);
    // Issue / hazard
    logic            issue_valid;
    logic            issue_long;
    logic [4:0]      issue_rd;
    logic            issue_waw;

    // ALU result stream
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_wd;

    // MUL/DIV result stream
    logic            md_valid;
    logic            md_ready;
    logic [4:0]      md_rd;
    logic [XLEN-1:0] md_wd;

    // Decode source lookup
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_busy;
    logic            rs2_busy;

    // Regfile write port
    logic            reg_write;
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;

    // Scoreboard side
    modport slave (
        input  issue_valid, issue_long, issue_rd,
        input  alu_valid, alu_rd, alu_wd,
        input  md_valid, md_rd, md_wd,
        input  rs1, rs2,
        output issue_waw, alu_ready, md_ready,
        output rs1_busy, rs2_busy,
        output reg_write, rd, wd
    );

    // Execute / decode side
    modport master (
        output issue_valid, issue_long, issue_rd,
        output alu_valid, alu_rd, alu_wd,
        output md_valid, md_rd, md_wd,
        output rs1, rs2,
        input  issue_waw, alu_ready, md_ready,
        input  rs1_busy, rs2_busy,
        input  reg_write, rd, wd
    );
endinterface

// File: rtl/wb_scoreboard.sv
// Purpose: single writer of the regfile port; merges ALU and MUL/DIV results and tracks pending long-latency destinations.
// Latency: 1 cycle from selection to reg_write; MUL/DIV results pass through a 1-entry skid buffer first.
// Backpressure: md_ready = !buffer full; alu_ready drops only while a starved MUL/DIV result is forced out.
//
// Ports:
//   clk   rising-edge clock for all state
//   rst   synchronous active-high reset
//   bus   wb_scoreboard_if.slave: issue/hazard, ALU and MUL/DIV result streams,
//         decode busy lookup and the registered regfile write port
module wb_scoreboard #(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    wb_scoreboard_if.slave bus
);

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] wd;
    } wr_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             buf_vld_q,   buf_vld_d;
    wr_t              buf_q,       buf_d;
    logic [SW-1:0]    starve_q,    starve_d;
    logic             reg_write_q, reg_write_d;
    wr_t              out_q,       out_d;
    logic             is_md_q,     is_md_d;
    logic [NREGS-1:0] sb_q,        sb_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic             starved;
    logic             alu_sel;
    logic             drain;
    logic             md_load;
    logic [NREGS-1:0] sb_set;
    logic [NREGS-1:0] sb_clr;

    always_comb begin
        // A buffered result that has waited the full limit pre-empts the ALU.
        starved = buf_vld_q && (starve_q == STARVE_MAX);
        alu_sel = bus.alu_valid && !starved;
        drain   = buf_vld_q && (starved || !bus.alu_valid);
        // md_ready is just !buf_vld_q, so a load and a drain never share an edge.
        md_load = bus.md_valid && !buf_vld_q;
    end

    // ------------------------------------------------------------------
    // Skid buffer and starvation counter
    // ------------------------------------------------------------------
    always_comb begin
        buf_vld_d = buf_vld_q;
        buf_d     = buf_q;
        starve_d  = starve_q;

        if (drain) begin
            buf_vld_d = 1'b0;
        end
        if (md_load) begin
            buf_vld_d = 1'b1;
            buf_d.rd  = bus.md_rd;
            buf_d.wd  = bus.md_wd;
        end

        // Counts cycles a full buffer was passed over; a fresh load starts at 0.
        if (!buf_vld_q || drain) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_comb begin
        reg_write_d = 1'b0;
        is_md_d     = 1'b0;
        out_d       = out_q;   // rd/wd hold when nothing is selected

        if (alu_sel) begin
            reg_write_d = 1'b1;
            out_d.rd    = bus.alu_rd;
            out_d.wd    = bus.alu_wd;
        end else if (drain) begin
            reg_write_d = 1'b1;
            is_md_d     = 1'b1;
            out_d       = buf_q;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    always_comb begin
        sb_set = '0;
        sb_clr = '0;

        if (bus.issue_valid && bus.issue_long && (bus.issue_rd != 5'd0)) begin
            sb_set[bus.issue_rd] = 1'b1;
        end
        // The bit clears on the edge the regfile commits the MUL/DIV write,
        // so decode sees busy=0 only once the value is readable.
        if (reg_write_q && is_md_q) begin
            sb_clr[out_q.rd] = 1'b1;
        end

        // A new long issue to the same register outranks the retiring write.
        sb_d    = (sb_q & ~sb_clr) | sb_set;
        sb_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld_q   <= 1'b0;
            buf_q       <= '0;
            starve_q    <= '0;
            reg_write_q <= 1'b0;
            out_q       <= '0;
            is_md_q     <= 1'b0;
            sb_q        <= '0;
        end else begin
            buf_vld_q   <= buf_vld_d;
            buf_q       <= buf_d;
            starve_q    <= starve_d;
            reg_write_q <= reg_write_d;
            out_q       <= out_d;
            is_md_q     <= is_md_d;
            sb_q        <= sb_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.md_ready  = !buf_vld_q;
    assign bus.alu_ready = !starved;
    assign bus.reg_write = reg_write_q;
    assign bus.rd        = out_q.rd;
    assign bus.wd        = out_q.wd;

    // Busy flags read state only; no same-cycle bypass of issue or commit.
    assign bus.rs1_busy  = sb_q[bus.rs1];
    assign bus.rs2_busy  = sb_q[bus.rs2];
    assign bus.issue_waw = bus.issue_valid && bus.issue_long && sb_q[bus.issue_rd];

endmodule

// File: tb/tb_wb_scoreboard.sv
// Purpose: self-checking bench for wb_scoreboard; directed scenarios followed by randomized traffic.
// Latency: expected writes are queued one cycle ahead and matched by a negedge monitor.
// Backpressure: the MUL/DIV source holds its request until the model reports acceptance.
`timescale 1ns/1ps
module tb_wb_scoreboard;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_scoreboard_if #(.XLEN(XLEN)) bus();

    wb_scoreboard #(
        .XLEN(XLEN),
        .NREGS(NREGS),
        .STARVE_LIMIT(STARVE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              cyc;
        logic [4:0]      rd;
        logic [XLEN-1:0] wd;
    } exp_t;
    exp_t expq[$];

    // Reference model: one waiting MUL/DIV result with its age in cycles,
    // a set of busy registers, and the MUL/DIV write currently being committed.
    bit              m_buf_vld;
    logic [4:0]      m_buf_rd;
    logic [XLEN-1:0] m_buf_wd;
    int              m_age;
    bit              m_busy[NREGS];
    bit              m_commit_vld;
    logic [4:0]      m_commit_rd;
    bit              dacc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_buf_vld    = 1'b0;
        m_buf_rd     = '0;
        m_buf_wd     = '0;
        m_age        = 0;
        m_commit_vld = 1'b0;
        m_commit_rd  = '0;
        for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, queue the write the model predicts, then advance to the next edge.
    task automatic step(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] awd,
                        input bit mv, input logic [4:0] mrd, input logic [XLEN-1:0] mwd,
                        input bit iv, input bit il, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2, output bit acc);
        bit   starved;
        bit   alu_go;
        bit   md_go;
        exp_t e;
        bus.alu_valid   = av;
        bus.alu_rd      = ard;
        bus.alu_wd      = awd;
        bus.md_valid    = mv;
        bus.md_rd       = mrd;
        bus.md_wd       = mwd;
        bus.issue_valid = iv;
        bus.issue_long  = il;
        bus.issue_rd    = ird;
        bus.rs1         = r1;
        bus.rs2         = r2;
        #1;
        starved = m_buf_vld && (m_age >= STARVE);
        alu_go  = av && !starved;
        md_go   = m_buf_vld && !alu_go;
        acc     = mv && !m_buf_vld;

        check("md_ready",  64'(bus.md_ready),  64'(!m_buf_vld));
        check("alu_ready", 64'(bus.alu_ready), 64'(!starved));
        check("rs1_busy",  64'(bus.rs1_busy),  64'(m_busy[r1]));
        check("rs2_busy",  64'(bus.rs2_busy),  64'(m_busy[r2]));
        check("issue_waw", 64'(bus.issue_waw), 64'(iv && il && m_busy[ird]));

        e.cyc = cyc + 1;
        if (alu_go) begin
            e.rd = ard;
            e.wd = awd;
            expq.push_back(e);
        end else if (md_go) begin
            e.rd = m_buf_rd;
            e.wd = m_buf_wd;
            expq.push_back(e);
        end

        if (m_commit_vld) m_busy[m_commit_rd] = 1'b0;
        if (iv && il && ird != 5'd0) m_busy[ird] = 1'b1;
        m_commit_vld = md_go;
        m_commit_rd  = m_buf_rd;

        if (md_go) begin
            m_buf_vld = 1'b0;
            m_age     = 0;
        end else if (m_buf_vld && m_age < STARVE) begin
            m_age++;
        end
        if (acc) begin
            m_buf_vld = 1'b1;
            m_buf_rd  = mrd;
            m_buf_wd  = mwd;
            m_age     = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] r1);
        step(0, 5'd0, '0, 0, 5'd0, '0, 0, 0, 5'd0, r1, 5'd0, dacc);
    endtask

    // Reset for one edge with the current inputs still applied; the write
    // predicted for that edge is discarded.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        while (expq.size() > 0 && expq[0].cyc <= cyc) expq.delete(0);
        model_reset();
    endtask

    // Monitor: every cycle, reg_write must match whether a write is due, and
    // a due write must carry the queued rd/wd.
    always @(negedge clk) begin : mon
        automatic bit   due = (expq.size() > 0) && (expq[0].cyc <= cyc);
        automatic exp_t e;
        check("reg_write", 64'(bus.reg_write), 64'(due));
        if (due) begin
            e = expq.pop_front();
            if (bus.reg_write) begin
                check("rd", 64'(bus.rd), 64'(e.rd));
                check("wd", 64'(bus.wd), 64'(e.wd));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit              sv;
        logic [4:0]      srd;
        logic [XLEN-1:0] swd;

        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_wd = 0;
        bus.md_valid = 0;  bus.md_rd = 0;  bus.md_wd = 0;
        bus.issue_valid = 0; bus.issue_long = 0; bus.issue_rd = 0;
        bus.rs1 = 5'd9; bus.rs2 = 5'd0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_reg_write", 64'(bus.reg_write), 64'd0);
        check("rst_rd",        64'(bus.rd),        64'd0);
        check("rst_wd",        64'(bus.wd),        64'd0);
        check("rst_md_ready",  64'(bus.md_ready),  64'd1);
        check("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("rst_rs1_busy",  64'(bus.rs1_busy),  64'd0);
        rst = 1'b0;

        // ALU only: written the following cycle, then idle
        step(1, 5'd3, 32'h2A, 0, 5'd0, '0, 0, 0, 5'd0, 5'd0, 5'd0, dacc);
        check("t1_reg_write", 64'(bus.reg_write), 64'd1);
        check("t1_rd",        64'(bus.rd),        64'd3);
        check("t1_wd",        64'(bus.wd),        64'h2A);
        idle(5'd0);
        check("t1_idle",      64'(bus.reg_write), 64'd0);

        // Scoreboard set / MUL/DIV write / clear visible a cycle after commit
        step(0, 5'd0, '0, 0, 5'd0, '0, 1, 1, 5'd5, 5'd5, 5'd0, dacc);
        check("t2_busy_set",  64'(bus.rs1_busy), 64'd1);
        step(0, 5'd0, '0, 1, 5'd5, 32'h64, 0, 0, 5'd0, 5'd5, 5'd0, dacc);
        idle(5'd5);
        check("t2_md_rd",     64'(bus.rd),       64'd5);
        check("t2_md_wd",     64'(bus.wd),       64'h64);
        check("t2_busy_hold", 64'(bus.rs1_busy), 64'd1);
        idle(5'd5);
        check("t2_busy_clr",  64'(bus.rs1_busy), 64'd0);

        // Conflict: ALU first, MUL/DIV waits in the buffer until ALU idles
        step(1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 0, 5'd0, 5'd0, 5'd0, dacc);
        check("t3_alu_first", 64'(bus.rd),       64'd1);
        check("t3_md_block",  64'(bus.md_ready), 64'd0);
        step(1, 5'd3, 32'hC3, 0, 5'd0, '0, 0, 0, 5'd0, 5'd0, 5'd0, dacc);
        check("t3_alu_again", 64'(bus.rd),       64'd3);
        idle(5'd0);
        check("t3_md_wd",     64'(bus.wd),       64'hB2);
        check("t3_md_free",   64'(bus.md_ready), 64'd1);

        // Starvation: four waiting cycles, then the ALU is held off once
        step(1, 5'd6, 32'h11, 1, 5'd4, 32'h44, 0, 0, 5'd0, 5'd0, 5'd0, dacc);
        for (int i = 0; i < STARVE; i++)
            step(1, 5'd6, 32'h20 + i, 0, 5'd0, '0, 0, 0, 5'd0, 5'd0, 5'd0, dacc);
        check("t4_alu_stall", 64'(bus.alu_ready), 64'd0);
        step(1, 5'd6, 32'h99, 0, 5'd0, '0, 0, 0, 5'd0, 5'd0, 5'd0, dacc);
        check("t4_md_wd",     64'(bus.wd),        64'h44);
        check("t4_alu_back",  64'(bus.alu_ready), 64'd1);

        // Set/clear race on x7, and long issue to x0
        step(0, 5'd0, '0, 0, 5'd0, '0, 1, 1, 5'd7, 5'd7, 5'd0, dacc);
        step(0, 5'd0, '0, 1, 5'd7, 32'h77, 0, 0, 5'd0, 5'd7, 5'd0, dacc);
        idle(5'd7);
        step(0, 5'd0, '0, 0, 5'd0, '0, 1, 1, 5'd7, 5'd7, 5'd0, dacc);
        check("t5_race_busy", 64'(bus.rs1_busy), 64'd1);
        step(0, 5'd0, '0, 0, 5'd0, '0, 1, 1, 5'd0, 5'd0, 5'd0, dacc);
        check("t5_x0_busy",   64'(bus.rs1_busy), 64'd0);

        // Reset with buffer full, sb[9] set and an ALU write in flight
        step(0, 5'd0, '0, 0, 5'd0, '0, 1, 1, 5'd9, 5'd9, 5'd9, dacc);
        step(1, 5'd1, 32'h1, 1, 5'd9, 32'h90, 0, 0, 5'd0, 5'd9, 5'd9, dacc);
        step(1, 5'd2, 32'h2, 0, 5'd0, '0, 0, 0, 5'd0, 5'd9, 5'd9, dacc);
        do_reset();
        check("t6_rs1_busy",  64'(bus.rs1_busy),  64'd0);
        check("t6_rs2_busy",  64'(bus.rs2_busy),  64'd0);
        check("t6_md_ready",  64'(bus.md_ready),  64'd1);
        check("t6_reg_write", 64'(bus.reg_write), 64'd0);
        bus.alu_valid = 0;

        // Randomized traffic with a holding MUL/DIV source and rare resets
        sv  = 0;
        srd = '0;
        swd = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                sv = 0;
            end else begin
                if (!sv && $urandom_range(0, 2) == 0) begin
                    sv  = 1;
                    srd = 5'($urandom_range(0, 7));
                    swd = $urandom;
                end
                step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom,
                     sv, srd, swd,
                     1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), dacc);
                if (dacc) sv = 0;
            end
        end

        repeat (8) idle(5'd0);
        @(negedge clk);
        #1;
        check("queue_drained", 64'(expq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
